// File: rtl/spike_event_encoder.sv
// Spike event encoder: turns LIF neuron spikes into event words of
// {inter-spike interval, membrane potential, drop flag}, buffers them in a
// small first-word-fall-through FIFO and reports a windowed spike rate.
module spike_event_encoder #(
    parameter int DEPTH       = 4,
    parameter int WINDOW_LOG2 = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     spike_in,
    input  logic [6:0]               v_mem_in,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [15:0]              ev_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               rate,
    output logic                     rate_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic                   spike_prev;
    logic [7:0]             isi_cnt;
    logic [7:0]             isi_field;
    logic                   det;
    logic                   pop;
    logic                   push;
    logic                   drop_pending;
    logic [15:0]            mem [DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic [WINDOW_LOG2-1:0] win_cnt;
    logic [7:0]             spk_cnt;
    logic [7:0]             spk_next;
    logic                   last_cycle;

    // Edge detection, event field formatting, FIFO handshake and rate helpers
    always_comb begin
        det        = enable & spike_in & ~spike_prev;
        isi_field  = (isi_cnt == 8'hFF) ? 8'hFF : isi_cnt + 8'd1;
        ev_valid   = (count != '0);
        ev_data    = ev_valid ? mem[rd_ptr] : 16'h0000;
        pop        = ev_valid & ev_ready;
        // A full FIFO still takes the new event when the head leaves this cycle.
        push       = det & ((count != FULL) | pop);
        last_cycle = enable & (win_cnt == '1);
        spk_next   = (det && spk_cnt != 8'hFF) ? spk_cnt + 8'd1 : spk_cnt;
        fifo_count = count;
    end

    // Spike history and inter-spike interval counter, frozen while disabled
    always_ff @(posedge clk) begin
        if (reset) begin
            spike_prev <= 1'b0;
            isi_cnt    <= 8'd0;
        end else if (enable) begin
            spike_prev <= spike_in;
            if (det)
                isi_cnt <= 8'd0;
            else if (isi_cnt != 8'hFF)
                isi_cnt <= isi_cnt + 8'd1;
        end
    end

    // Event storage; contents need no reset since ev_data is gated by ev_valid
    always_ff @(posedge clk) begin
        if (!reset && push)
            mem[wr_ptr] <= {isi_field, v_mem_in, drop_pending};
    end

    // FIFO pointers, occupancy and sticky drop indication
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            drop_pending <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push)
                drop_pending <= 1'b0;
            else if (det)
                drop_pending <= 1'b1;
        end
    end

    // Windowed spike rate; the closing cycle's own detection is included
    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt    <= '0;
            spk_cnt    <= 8'd0;
            rate       <= 8'd0;
            rate_valid <= 1'b0;
        end else begin
            rate_valid <= 1'b0;
            if (enable) begin
                win_cnt <= win_cnt + WINDOW_LOG2'(1);
                if (last_cycle) begin
                    rate       <= spk_next;
                    rate_valid <= 1'b1;
                    spk_cnt    <= 8'd0;
                end else begin
                    spk_cnt <= spk_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_spike_event_encoder.sv
// Testbench for spike_event_encoder: directed scenarios plus random traffic,
// checked by a scoreboard fed from an event-level reference model.
module tb_spike_event_encoder;

    localparam int DEPTH = 4;
    localparam int WL    = 4;
    localparam int WIN   = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        spike_in;
    logic [6:0]  v_mem_in;
    logic        ev_valid;
    logic        ev_ready;
    logic [15:0] ev_data;
    logic [2:0]  fifo_count;
    logic [7:0]  rate;
    logic        rate_valid;

    spike_event_encoder #(.DEPTH(DEPTH), .WINDOW_LOG2(WL)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .spike_in   (spike_in),
        .v_mem_in   (v_mem_in),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_data    (ev_data),
        .fifo_count (fifo_count),
        .rate       (rate),
        .rate_valid (rate_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [15:0] sb[$];
    int          m_count = 0;
    logic        m_drop = 1'b0;
    logic        m_prev = 1'b0;
    int          m_en_idx = 0;
    int          m_last_det = -1;
    int          m_win_spk = 0;
    int          m_rate = 0;
    logic        m_rate_valid = 1'b0;
    logic        m_after_reset = 1'b0;
    bit          started = 1'b0;

    logic [15:0] last_pop = 16'h0;
    int          pop_cnt = 0;

    // Reference model: evaluates each clock edge from the inputs seen there
    always @(posedge clk) begin
        logic pop_m, det_m, acc_m;
        int   isi;
        started = 1'b1;
        if (reset) begin
            sb.delete();
            m_count = 0; m_drop = 1'b0; m_prev = 1'b0;
            m_en_idx = 0; m_last_det = -1; m_win_spk = 0;
            m_rate = 0; m_rate_valid = 1'b0; m_after_reset = 1'b1;
        end else begin
            m_after_reset = 1'b0;
            m_rate_valid  = 1'b0;
            pop_m = (m_count != 0) && ev_ready;
            det_m = enable && spike_in && !m_prev;
            acc_m = 1'b0;
            if (det_m) begin
                isi = m_en_idx - m_last_det;
                if (isi > 255) isi = 255;
                if (m_count < DEPTH || pop_m) begin
                    sb.push_back({isi[7:0], v_mem_in, m_drop});
                    m_drop = 1'b0;
                    acc_m  = 1'b1;
                end else begin
                    m_drop = 1'b1;
                end
                m_last_det = m_en_idx;
            end
            m_count = m_count + int'(acc_m) - int'(pop_m);
            if (enable) begin
                m_prev = spike_in;
                if (det_m && m_win_spk < 255) m_win_spk++;
                if (m_en_idx % WIN == WIN - 1) begin
                    m_rate = m_win_spk;
                    m_rate_valid = 1'b1;
                    m_win_spk = 0;
                end
                m_en_idx++;
            end
        end
    end

    // Monitor: compares DUT outputs mid-cycle and retires delivered events
    always @(negedge clk) begin
        if (started) begin
            chk("fifo_count", 32'(fifo_count), m_count);
            chk("ev_valid", 32'(ev_valid), 32'(m_count != 0));
            chk("rate", 32'(rate), m_rate);
            chk("rate_valid", 32'(rate_valid), 32'(m_rate_valid));
            if (m_after_reset) chk("ev_data_after_reset", 32'(ev_data), 32'd0);
            if (ev_valid && ev_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL ev_data: got %0h expected none (scoreboard empty) at %0t", ev_data, $time);
                end else begin
                    chk("ev_data", 32'(ev_data), 32'(sb.pop_front()));
                end
                last_pop = ev_data;
                pop_cnt++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int gap);
        spike_in = 1'b1;
        v_mem_in = 7'($urandom);
        step(1);
        spike_in = 1'b0;
        step(gap - 1);
    endtask

    // Stimulus: directed scenarios followed by random traffic
    initial begin
        int p0;
        reset = 1'b1; enable = 1'b0; spike_in = 1'b0; ev_ready = 1'b0; v_mem_in = 7'h0;
        step(2);
        @(negedge clk);
        chk("rst_valid", 32'(ev_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_rate", 32'(rate), 32'd0);

        // single spike at enabled cycle 5
        step(1);
        reset = 1'b0; enable = 1'b1; ev_ready = 1'b1;
        step(5);
        spike_in = 1'b1; v_mem_in = 7'h55;
        step(1);
        spike_in = 1'b0;
        @(negedge clk);
        chk("single_valid", 32'(ev_valid), 32'd1);
        chk("single_data", 32'(ev_data), 32'h06AA);
        step(1);
        @(negedge clk);
        chk("single_gone", 32'(ev_valid), 32'd0);

        // overflow with stalled consumer
        step(1);
        ev_ready = 1'b0;
        for (int i = 0; i < 6; i++) pulse(4);
        chk("ovf_count", 32'(fifo_count), 32'd4);
        p0 = pop_cnt;
        ev_ready = 1'b1;
        step(8);
        chk("ovf_delivered", pop_cnt - p0, 32'd4);
        pulse(4);
        chk("ovf_drop_flag", 32'(last_pop[0]), 32'd1);
        pulse(4);
        chk("ovf_flag_clear", 32'(last_pop[0]), 32'd0);

        // level hold then saturated interval
        p0 = pop_cnt;
        spike_in = 1'b1;
        step(10);
        spike_in = 1'b0;
        step(300);
        chk("hold_one_event", pop_cnt - p0, 32'd1);
        pulse(4);
        chk("isi_saturated", 32'(last_pop[15:8]), 32'd255);

        // rate window: spikes at window cycles 3,6,9,12,15
        while (m_en_idx % WIN != 0) step(1);
        for (int c = 0; c < WIN; c++) begin
            spike_in = (c % 3 == 0) && (c != 0);
            v_mem_in = 7'($urandom);
            step(1);
        end
        spike_in = 1'b0;
        @(negedge clk);
        chk("rate_five", 32'(rate), 32'd5);
        chk("rate_pulse", 32'(rate_valid), 32'd1);
        step(1);
        @(negedge clk);
        chk("rate_pulse_end", 32'(rate_valid), 32'd0);
        step(15);
        @(negedge clk);
        chk("rate_empty", 32'(rate), 32'd0);
        chk("rate_empty_pulse", 32'(rate_valid), 32'd1);

        // enable gating: no event while disabled, interval counter frozen
        step(1);
        pulse(5);
        p0 = pop_cnt;
        enable = 1'b0;
        step(3);
        pulse(4);
        chk("gate_no_event", pop_cnt - p0, 32'd0);
        chk("gate_count", 32'(fifo_count), 32'd0);
        enable = 1'b1;
        pulse(4);
        chk("gate_isi_frozen", 32'(last_pop[15:8]), 32'd5);

        // reset discards buffered events
        ev_ready = 1'b0;
        for (int i = 0; i < 3; i++) pulse(3);
        chk("buffered_three", 32'(fifo_count), 32'd3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_count", 32'(fifo_count), 32'd0);
        chk("midrst_valid", 32'(ev_valid), 32'd0);
        chk("midrst_rate", 32'(rate), 32'd0);
        chk("midrst_data", 32'(ev_data), 32'd0);

        // random traffic
        step(1);
        for (int i = 0; i < 3000; i++) begin
            enable   = ($urandom_range(0, 3) != 0);
            spike_in = ($urandom_range(0, 9) < 3);
            ev_ready = ($urandom_range(0, 1) == 1);
            v_mem_in = 7'($urandom);
            reset    = ($urandom_range(0, 399) == 0);
            step(1);
        end
        reset = 1'b0; enable = 1'b0; spike_in = 1'b0; ev_ready = 1'b1;
        step(10);
        @(negedge clk);
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
